serial_sum_collector: RTL and testbench

- Serial-in, parallel-out receive end of the serial adder datapath.
- Takes the LSB-first sum bit stream from the serial adder and shifts it into a WIDTH-bit word.
- Counts the accepted bits, raises done with the assembled word, and holds it until the consumer acknowledges.
- It is the mirror of the parallel-load shift register that feeds the adder's operands.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/sipo_bit_counter.sv | 40 ++++
 rtl/serial_sum_collector.sv | 165 ++++++++++++++++
 tb/tb_serial_sum_collector.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the serial adder datapath: the default word
// length used by the operand shift registers and the sum collector, and
// the collector's state type.
//
// Optional feature macro used by importers: SERIAL_SUM_CARRY_EN.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter
// Counts accepted serial bits for the sum collector.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear (priority over inc)
//   inc    in   count one accepted bit
//   count  out  bits accepted so far (saturates at WIDTH)
//   last   out  count == WIDTH-1, i.e. the next accepted bit completes the word
module sipo_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         inc,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != CNT_W'(WIDTH))) begin
            // Saturating: the count can never run past WIDTH.
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
    assign last  = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_sum_collector.sv
// serial_sum_collector
// Receive end of the serial adder: shifts the LSB-first sum stream into a
// WIDTH-bit word, raises done with the assembled word and holds it until
// the consumer acknowledges.
//
// Handshake: done=1 means result (and overflow when present) is valid and
// stable; the consumer releases it with ack=1 (-> IDLE) or start=1
// (-> new collection). start has priority over ack. enable marks a valid
// sum_bit and is only honoured while collecting.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             arm a new collection (clears shifter and counter)
//   enable, sum_bit   serial sum bit qualifier and data, LSB first
//   ack               consumer has taken result
//   result            assembled word, stable while done=1
//   done, busy        result valid / collection in progress
//   o_dbg_state       current FSM state
//   o_dbg_count       current bit count
//   carry_out         (SERIAL_SUM_CARRY_EN) adder carry, sampled with last bit
//   overflow          (SERIAL_SUM_CARRY_EN) carry of the completed word
//
// Optional feature macro: SERIAL_SUM_CARRY_EN.
module serial_sum_collector
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         enable,
    input  logic                         sum_bit,
    input  logic                         ack,
`ifdef SERIAL_SUM_CARRY_EN
    input  logic                         carry_out,
    output logic                         overflow,
`endif
    output logic [WIDTH-1:0]             result,
    output logic                         done,
    output logic                         busy,
    output state_t                       o_dbg_state,
    output logic [$clog2(WIDTH+1)-1:0]   o_dbg_count
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_sr_shifted;
    logic               w_clr;
    logic               w_accept;
    logic               w_complete;
    logic               w_last;
    logic [CNT_W-1:0]   w_count;

    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .inc   (w_accept),
        .count (w_count),
        .last  (w_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = COLLECT;
            end
            COLLECT: begin
                // A restart keeps us in COLLECT; otherwise leave on the last bit.
                if (!start && enable && w_last) w_state_nxt = DONE;
            end
            DONE: begin
                if (start)    w_state_nxt = COLLECT;
                else if (ack) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / control logic
    always_comb begin
        w_clr      = 1'b0;
        w_accept   = 1'b0;
        w_complete = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = start;
            end
            COLLECT: begin
                busy       = 1'b1;
                w_clr      = start;
                // A bit arriving together with start is discarded.
                w_accept   = enable && !start;
                w_complete = enable && !start && w_last;
            end
            DONE: begin
                done  = 1'b1;
                w_clr = start;
            end
            default: ;
        endcase
    end

    assign w_sr_shifted = {sum_bit, r_sr[WIDTH-1:1]};

    // Shift path and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr     <= '0;
            r_result <= '0;
        end else begin
            if (w_clr) begin
                r_sr <= '0;
            end else if (w_accept) begin
                r_sr <= w_sr_shifted;
            end
            // result moves only on completion, never while collecting.
            if (w_complete) begin
                r_result <= w_sr_shifted;
            end
        end
    end

`ifdef SERIAL_SUM_CARRY_EN
    logic r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_complete) begin
            r_overflow <= carry_out;
        end else if ((r_state == DONE) && (start || ack)) begin
            // Cleared together with done.
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;
`endif

    assign result      = r_result;
    assign o_dbg_state = r_state;
    assign o_dbg_count = w_count;

endmodule

// File: tb/tb_serial_sum_collector.sv
module tb_serial_sum_collector;
  import serial_adder_pkg::*;

  localparam int W = 8;
  localparam int CW = $clog2(W + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic enable = 1'b0;
  logic sum_bit = 1'b0;
  logic ack = 1'b0;
  logic carry_in_tb = 1'b0;
  logic [W-1:0] result;
  logic done;
  logic busy;
  state_t dbg_state;
  logic [CW-1:0] dbg_count;
`ifdef SERIAL_SUM_CARRY_EN
  logic overflow;
`endif

  serial_sum_collector #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .enable      (enable),
    .sum_bit     (sum_bit),
    .ack         (ack),
`ifdef SERIAL_SUM_CARRY_EN
    .carry_out   (carry_in_tb),
    .overflow    (overflow),
`endif
    .result      (result),
    .done        (done),
    .busy        (busy),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: accepted bits kept in a list, word assembled at the end.
  bit           m_active = 1'b0;
  bit           m_done = 1'b0;
  bit           m_ovf = 1'b0;
  logic [W-1:0] m_result = '0;
  bit           m_bits[$];

  always @(negedge rst_n) begin
    m_active = 1'b0;
    m_done = 1'b0;
    m_ovf = 1'b0;
    m_result = '0;
    m_bits.delete();
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_done) begin
        if (start) begin
          m_done = 1'b0; m_ovf = 1'b0; m_active = 1'b1; m_bits.delete();
        end else if (ack) begin
          m_done = 1'b0; m_ovf = 1'b0;
        end
      end else if (m_active) begin
        if (start) begin
          m_bits.delete();
        end else if (enable) begin
          m_bits.push_back(sum_bit);
          if (m_bits.size() == W) begin
            for (int i = 0; i < W; i++) m_result[i] = m_bits[i];
            m_active = 1'b0;
            m_done = 1'b1;
            m_ovf = carry_in_tb;
          end
        end
      end else if (start) begin
        m_active = 1'b1;
        m_bits.delete();
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    state_t exp_st;
    if (chk_en) begin
      exp_st = m_done ? DONE : (m_active ? COLLECT : IDLE);
      check("done", 32'(done), 32'(m_done));
      check("busy", 32'(busy), 32'(m_active));
      check("result", 32'(result), 32'(m_result));
      check("state", 32'(dbg_state), 32'(exp_st));
`ifdef SERIAL_SUM_CARRY_EN
      check("overflow", 32'(overflow), 32'(m_ovf));
`endif
    end
  end

  // Driver: apply inputs at a falling edge, hold for one cycle.
  task automatic drive(input logic st, input logic en, input logic b, input logic ak);
    start = st; enable = en; sum_bit = b; ack = ak;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    for (int i = 0; i < W; i++) begin
      carry_in_tb = 1'b0;
      drive(1'b0, 1'b1, w[i], 1'b0);
      if (gaps) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] w_ca;
    logic [W-1:0] w_05;
    w_ca = 8'hCA;
    w_05 = 8'h05;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_result", 32'(result), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // Plain stream 0,1,0,1,0,0,1,1 -> CA
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(w_ca, 1'b0);
    check("ca_done", 32'(done), 32'h1);
    check("ca_busy", 32'(busy), 32'h0);
    check("ca_result", 32'(result), 32'hCA);
    check("ca_model", 32'(m_result), 32'hCA);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("ack_done", 32'(done), 32'h0);

    // Same stream with enable gaps
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(w_ca, 1'b1);
    check("gap_result", 32'(result), 32'hCA);

    // Hold in DONE with enable pulses, then ack
    repeat (5) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("hold_result", 32'(result), 32'hCA);
    check("hold_done", 32'(done), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_ack_done", 32'(done), 32'h0);
    check("hold_ack_state", 32'(dbg_state), 32'(IDLE));

    // Restart after 3 bits; restart cycle carries an enabled bit too
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    send_word(w_05, 1'b0);
    check("restart_result", 32'(result), 32'h05);

    // start and ack together in DONE, then an all-ones word with carry
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("sa_done", 32'(done), 32'h0);
    check("sa_busy", 32'(busy), 32'h1);
    for (int i = 0; i < W; i++) begin
      carry_in_tb = (i == W - 1);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
    end
    carry_in_tb = 1'b0;
    check("ff_result", 32'(result), 32'hFF);
`ifdef SERIAL_SUM_CARRY_EN
    check("ff_overflow", 32'(overflow), 32'h1);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Async reset after 4 bits
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", 32'(result), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      carry_in_tb = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
